mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 35 +++
 rtl/common.vh | 9 +
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Types and helpers shared by the memory arbiter and code that talks to it.
`include "common.vh"

package mem_arbiter_pkg;

  // Which requester owns the current bus transaction
  typedef enum logic {
    CLIENT_IF  = 1'b0,
    CLIENT_MEM = 1'b1
  } client_e;

  // Registered command presented on the shared bus
  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_cmd_t;

  localparam int unsigned EXC_W = `EXC_CODE_WIDTH;
  localparam logic [`EXC_CODE_WIDTH-1:0] EC_NONE_C    = `EC_NONE;
  localparam logic [`EXC_CODE_WIDTH-1:0] EC_BUS_ERR_C = `EC_BUS_ERR;
  localparam logic [3:0] IF_BYTE_EN = 4'hF;

  // Instruction fetches are always full-word reads with no store data
  function automatic bus_cmd_t fetch_cmd(input logic [31:0] addr);
    bus_cmd_t cmd;
    cmd.we    = 1'b0;
    cmd.be    = IF_BYTE_EN;
    cmd.addr  = addr;
    cmd.wdata = '0;
    return cmd;
  endfunction

endpackage

// File: rtl/common.vh
// Shared exception-code definitions used by the memory arbiter and its clients.
`ifndef COMMON_VH
`define COMMON_VH

`define EXC_CODE_WIDTH 4
`define EC_NONE        4'd0
`define EC_BUS_ERR     4'd1

`endif

// File: rtl/mem_arbiter.sv
// Two-client (instruction fetch / MEM stage) arbiter for a single shared bus.
// MEM has priority; a stuck bus is aborted after TIMEOUT_CYC cycles with a
// bus-error exception. Optional IF anti-starvation guard is enabled by
// defining MEM_ARB_IF_STARVE_GUARD_EN.
`include "common.vh"

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC  = 255,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       if_req,
  input  logic [31:0]                if_addr,
  output logic [31:0]                if_rdata,
  output logic [`EXC_CODE_WIDTH-1:0] if_exc_code,
  output logic                       if_ack,
  input  logic                       mem_req,
  input  logic                       mem_we,
  input  logic [3:0]                 mem_be,
  input  logic [31:0]                mem_addr,
  input  logic [31:0]                mem_wdata,
  output logic [31:0]                mem_rdata,
  output logic [`EXC_CODE_WIDTH-1:0] mem_exc_code,
  output logic                       mem_ack,
  output logic                       bus_req,
  output logic                       bus_we,
  output logic [3:0]                 bus_be,
  output logic [31:0]                bus_addr,
  output logic [31:0]                bus_wdata,
  input  logic [31:0]                bus_rdata,
  input  logic                       bus_ack,
  input  logic [`EXC_CODE_WIDTH-1:0] bus_exc_code,
  output logic                       busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_IF  = 2'd1,
    GNT_MEM = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  state_e           state_q;
  state_e           state_d;
  bus_cmd_t         cmd_q;
  logic [TMO_W-1:0] tmo_q;
  logic             tmo_last;
  logic             force_if;
  client_e          gnt_client;

  // The last waiting cycle is the one where the counter sits one below the limit
  assign tmo_last   = (tmo_q == TMO_LAST);
  assign gnt_client = (state_q == GNT_MEM) ? CLIENT_MEM : CLIENT_IF;
  assign busy       = (state_q != IDLE);

  assign bus_we    = cmd_q.we;
  assign bus_be    = cmd_q.be;
  assign bus_addr  = cmd_q.addr;
  assign bus_wdata = cmd_q.wdata;

`ifdef MEM_ARB_IF_STARVE_GUARD_EN
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_q;

  assign force_if = if_req && (starve_q == STARVE_MAX);

  // Count back-to-back MEM wins that left a fetch waiting; saturate at the limit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else if (state_q == IDLE) begin
      if (!if_req || state_d == GNT_IF) begin
        starve_q <= '0;
      end else if (state_d == GNT_MEM && starve_q != STARVE_MAX) begin
        starve_q <= starve_q + 1'b1;
      end
    end
  end
`else
  assign force_if = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Arbitration and transaction sequencing
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mem_req && !force_if) begin
          state_d = GNT_MEM;
        end else if (if_req) begin
          state_d = GNT_IF;
        end
      end
      GNT_IF, GNT_MEM: begin
        if (bus_ack || tmo_last) begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus command launch, timeout counting, result capture and ack pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_q        <= '0;
      bus_req      <= 1'b0;
      tmo_q        <= '0;
      if_ack       <= 1'b0;
      mem_ack      <= 1'b0;
      if_rdata     <= '0;
      mem_rdata    <= '0;
      if_exc_code  <= EC_NONE_C;
      mem_exc_code <= EC_NONE_C;
    end else begin
      if_ack  <= 1'b0;
      mem_ack <= 1'b0;
      case (state_q)
        IDLE: begin
          if (state_d == GNT_MEM) begin
            cmd_q   <= '{we: mem_we, be: mem_be, addr: mem_addr, wdata: mem_wdata};
            bus_req <= 1'b1;
            tmo_q   <= '0;
          end else if (state_d == GNT_IF) begin
            cmd_q   <= fetch_cmd(if_addr);
            bus_req <= 1'b1;
            tmo_q   <= '0;
          end
        end
        GNT_IF, GNT_MEM: begin
          if (bus_ack || tmo_last) begin
            bus_req <= 1'b0;
            if (gnt_client == CLIENT_MEM) begin
              mem_ack      <= 1'b1;
              mem_rdata    <= bus_ack ? bus_rdata : '0;
              mem_exc_code <= bus_ack ? bus_exc_code : EC_BUS_ERR_C;
            end else begin
              if_ack      <= 1'b1;
              if_rdata    <= bus_ack ? bus_rdata : '0;
              if_exc_code <= bus_ack ? bus_exc_code : EC_BUS_ERR_C;
            end
          end
          if (!bus_ack) begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
